// File: rtl/ltc2600_spi_monitor.sv
// Passive receiver for the LTC2600 DAC serial link: decodes 24/32-bit frames
// and keeps a shadow copy of the eight input/DAC register pairs for readback.
module ltc2600_spi_monitor #(
   parameter int DATA_WIDTH  = 16,
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  csb,
   input  logic                  clrb,
   output logic                  frame_valid,
   output logic                  frame_error,
   output logic [3:0]            frame_cmd,
   output logic [3:0]            frame_addr,
   output logic [DATA_WIDTH-1:0] frame_data,
   output logic [15:0]           frame_count,
   input  logic [2:0]            rd_chan,
   output logic [DATA_WIDTH-1:0] rd_input_value,
   output logic [DATA_WIDTH-1:0] rd_dac_value
);

   localparam int SR_W    = DATA_WIDTH + 16;
   localparam int FRAME_S = DATA_WIDTH + 8;
   localparam int FRAME_L = DATA_WIDTH + 16;
   localparam int CNT_W   = $clog2(FRAME_L + 2);
   localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(FRAME_S);
   localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(FRAME_L);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_L + 1);

   typedef enum logic [1:0] {
      ST_WAIT_HIGH,
      ST_IDLE,
      ST_SHIFT,
      ST_DECODE
   } state_e;

   // Synchronizer chains, one 4-bit lane per stage: {clrb, csb, sdi, sck}.
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_d [SYNC_STAGES];
   logic [3:0] pins_s;
   logic       sck_s, sdi_s, csb_s, clrb_s;

   logic       sck_prev_q, sck_prev_d, csb_prev_q, csb_prev_d;
   logic       sck_rise_q, sck_rise_d, csb_rise_q, csb_rise_d, csb_fall_q, csb_fall_d;
   logic       sdi_q, sdi_d;

   state_e                  state_q, state_d;
   logic [SR_W-1:0]         sr_q, sr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    valid_q, valid_d, error_q, error_d;
   logic [3:0]              cmd_q, cmd_d, addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [15:0]             frame_count_q, frame_count_d;

   logic [DATA_WIDTH-1:0]   input_q [N_CH];
   logic [DATA_WIDTH-1:0]   input_d [N_CH];
   logic [DATA_WIDTH-1:0]   dac_q   [N_CH];
   logic [DATA_WIDTH-1:0]   dac_d   [N_CH];
   logic [DATA_WIDTH-1:0]   rd_input_q, rd_input_d, rd_dac_q, rd_dac_d;

   logic [3:0]              f_cmd, f_addr;
   logic [DATA_WIDTH-1:0]   f_data;
   logic                    frame_good, addr_hit, commit;
   logic                    sr_top_unused;

   always_comb begin
      sync_d[0] = {clrb, csb, sdi, sck};
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign pins_s = sync_q[SYNC_STAGES-1];
   assign sck_s  = pins_s[0];
   assign sdi_s  = pins_s[1];
   assign csb_s  = pins_s[2];
   assign clrb_s = pins_s[3];

   // Edge strobes are registered, so sdi is delayed by one flop to stay aligned with sck_rise_q.
   always_comb begin
      sck_prev_d = sck_s;
      csb_prev_d = csb_s;
      sck_rise_d = sck_s & ~sck_prev_q;
      csb_rise_d = csb_s & ~csb_prev_q;
      csb_fall_d = ~csb_s & csb_prev_q;
      sdi_d      = sdi_s;
   end

   assign f_cmd         = sr_q[DATA_WIDTH+7 -: 4];
   assign f_addr        = sr_q[DATA_WIDTH+3 -: 4];
   assign f_data        = sr_q[DATA_WIDTH-1:0];
   assign sr_top_unused = sr_q[SR_W-1];
   assign frame_good    = (cnt_q == CNT_SHORT) || (cnt_q == CNT_LONG);
   assign addr_hit      = (f_addr == 4'hF) || (int'(f_addr) < N_CH);
   assign commit        = (state_q == ST_DECODE) && frame_good;

   // NOTE: every variable gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      cnt_d         = cnt_q;
      valid_d       = 1'b0;
      error_d       = 1'b0;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      data_d        = data_q;
      frame_count_d = frame_count_q;
      case (state_q)
         ST_WAIT_HIGH: begin
            if (csb_s) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (csb_fall_q) begin
               state_d = ST_SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (csb_rise_q) begin
               state_d = ST_DECODE;
            end else if (sck_rise_q) begin
               sr_d = {sr_q[SR_W-2:0], sdi_q};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
            if (frame_good) begin
               valid_d       = 1'b1;
               cmd_d         = f_cmd;
               addr_d        = f_addr;
               data_d        = f_data;
               frame_count_d = frame_count_q + 16'd1;
            end else begin
               error_d = 1'b1;
            end
         end
         default: state_d = ST_WAIT_HIGH;
      endcase
   end

   always_comb begin
      input_d = input_q;
      dac_d   = dac_q;
      if (!clrb_s) begin
         for (int i = 0; i < N_CH; i++) begin
            input_d[i] = '0;
            dac_d[i]   = '0;
         end
      end else if (commit && addr_hit) begin
         for (int i = 0; i < N_CH; i++) begin
            if (f_addr == 4'hF || f_addr == 4'(i)) begin
               case (f_cmd)
                  4'd0: input_d[i] = f_data;
                  4'd1: dac_d[i]   = input_q[i];
                  4'd2: input_d[i] = f_data;
                  4'd3: begin
                     input_d[i] = f_data;
                     dac_d[i]   = f_data;
                  end
                  default: ;
               endcase
            end
         end
         // NOTE: blocking assignment here is deliberate: dac_d picks up the input_d value written just above.
         if (f_cmd == 4'd2) begin
            for (int i = 0; i < N_CH; i++) dac_d[i] = input_d[i];
         end
      end
   end

   always_comb begin
      rd_input_d = '0;
      rd_dac_d   = '0;
      if (int'(rd_chan) < N_CH) begin
         rd_input_d = input_q[rd_chan];
         rd_dac_d   = dac_q[rd_chan];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         sck_prev_q    <= 1'b0;
         csb_prev_q    <= 1'b0;
         sck_rise_q    <= 1'b0;
         csb_rise_q    <= 1'b0;
         csb_fall_q    <= 1'b0;
         sdi_q         <= 1'b0;
         state_q       <= ST_WAIT_HIGH;
         sr_q          <= '0;
         cnt_q         <= '0;
         valid_q       <= 1'b0;
         error_q       <= 1'b0;
         cmd_q         <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         frame_count_q <= '0;
         // NOTE: the shadow arrays are reset because readback must show zeros straight out of reset.
         for (int i = 0; i < N_CH; i++) begin
            input_q[i] <= '0;
            dac_q[i]   <= '0;
         end
         rd_input_q    <= '0;
         rd_dac_q      <= '0;
      end else begin
         sync_q        <= sync_d;
         sck_prev_q    <= sck_prev_d;
         csb_prev_q    <= csb_prev_d;
         sck_rise_q    <= sck_rise_d;
         csb_rise_q    <= csb_rise_d;
         csb_fall_q    <= csb_fall_d;
         sdi_q         <= sdi_d;
         state_q       <= state_d;
         sr_q          <= sr_d;
         cnt_q         <= cnt_d;
         valid_q       <= valid_d;
         error_q       <= error_d;
         cmd_q         <= cmd_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         frame_count_q <= frame_count_d;
         input_q       <= input_d;
         dac_q         <= dac_d;
         rd_input_q    <= rd_input_d;
         rd_dac_q      <= rd_dac_d;
      end
   end

   assign frame_valid    = valid_q;
   assign frame_error    = error_q;
   assign frame_cmd      = cmd_q;
   assign frame_addr     = addr_q;
   assign frame_data     = data_q;
   assign frame_count    = frame_count_q;
   assign rd_input_value = rd_input_q;
   assign rd_dac_value   = rd_dac_q;

endmodule

// File: tb/tb_ltc2600_spi_monitor.sv
// Directed bench for ltc2600_spi_monitor: drives SPI frames on the pins and
// compares decode results and shadow readback against hand-computed values.
module tb_ltc2600_spi_monitor;

   localparam int DW  = 16;
   localparam int SS  = 2;
   localparam int LAT = SS + 2;

   logic          clk;
   logic          rst;
   logic          sck, sdi, csb, clrb;
   logic          frame_valid, frame_error;
   logic [3:0]    frame_cmd, frame_addr;
   logic [DW-1:0] frame_data;
   logic [15:0]   frame_count;
   logic [2:0]    rd_chan;
   logic [DW-1:0] rd_input_value, rd_dac_value;

   int checks   = 0;
   int failures = 0;

   ltc2600_spi_monitor #(.DATA_WIDTH(DW), .N_CH(8), .SYNC_STAGES(SS)) dut (
      .clk            (clk),
      .rst            (rst),
      .sck            (sck),
      .sdi            (sdi),
      .csb            (csb),
      .clrb           (clrb),
      .frame_valid    (frame_valid),
      .frame_error    (frame_error),
      .frame_cmd      (frame_cmd),
      .frame_addr     (frame_addr),
      .frame_data     (frame_data),
      .frame_count    (frame_count),
      .rd_chan        (rd_chan),
      .rd_input_value (rd_input_value),
      .rd_dac_value   (rd_dac_value)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sck_bit(input logic b);
      sdi = b;
      wait_clks(3);
      sck = 1'b1;
      wait_clks(3);
      sck = 1'b0;
   endtask

   task automatic start_frame();
      @(negedge clk);
      csb = 1'b0;
      wait_clks(4);
   endtask

   // Raises csb (optionally together with one more sck rise) and watches the pulses.
   task automatic end_frame(input logic extra, output int lat, output int nv, output int ne);
      if (extra) begin
         sdi = 1'b1;
         wait_clks(3);
         sck = 1'b1;
         csb = 1'b1;
      end else begin
         wait_clks(3);
         csb = 1'b1;
      end
      lat = -1;
      nv  = 0;
      ne  = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (frame_valid) nv++;
         if (frame_error) ne++;
         if ((frame_valid || frame_error) && lat < 0) lat = n;
      end
      sck = 1'b0;
      wait_clks(4);
   endtask

   task automatic send_frame(input logic [31:0] bits, input int nbits, input logic extra,
                             output int lat, output int nv, output int ne);
      start_frame();
      for (int i = nbits - 1; i >= 0; i--) sck_bit(bits[i]);
      end_frame(extra, lat, nv, ne);
   endtask

   task automatic read_ch(input int ch, output logic [DW-1:0] iv, output logic [DW-1:0] dv);
      @(negedge clk);
      rd_chan = 3'(ch);
      @(posedge clk);
      #1;
      iv = rd_input_value;
      dv = rd_dac_value;
   endtask

   initial begin
      int lat, nv, ne;
      logic [DW-1:0] iv, dv;

      rst  = 1'b1;
      csb  = 1'b1;
      sck  = 1'b0;
      sdi  = 1'b0;
      clrb = 1'b1;
      rd_chan = 3'd0;
      wait_clks(4);
      check("rst_valid", frame_valid, 0);
      check("rst_error", frame_error, 0);
      check("rst_count", frame_count, 0);
      check("rst_data", frame_data, 0);
      check("rst_cmd", frame_cmd, 0);
      check("rst_rd_in", rd_input_value, 0);
      check("rst_rd_dac", rd_dac_value, 0);
      rst = 1'b0;
      wait_clks(6);

      // 24-bit write-and-update to channel 2
      send_frame(32'h0032_ABCD, 24, 1'b0, lat, nv, ne);
      check("t1_latency", lat, LAT);
      check("t1_nvalid", nv, 1);
      check("t1_nerror", ne, 0);
      check("t1_count", frame_count, 1);
      check("t1_cmd", frame_cmd, 3);
      check("t1_addr", frame_addr, 2);
      check("t1_data", frame_data, 16'hABCD);
      read_ch(2, iv, dv);
      check("t1_in2", iv, 16'hABCD);
      check("t1_dac2", dv, 16'hABCD);
      read_ch(0, iv, dv);
      check("t1_dac0", dv, 0);

      // 32-bit frame with junk prefix: write input 5, then update dac 5
      send_frame(32'hFF05_1234, 32, 1'b0, lat, nv, ne);
      check("t2a_latency", lat, LAT);
      check("t2a_nvalid", nv, 1);
      read_ch(5, iv, dv);
      check("t2a_in5", iv, 16'h1234);
      check("t2a_dac5", dv, 16'h0000);
      send_frame(32'h0015_0000, 24, 1'b0, lat, nv, ne);
      check("t2b_nvalid", nv, 1);
      read_ch(5, iv, dv);
      check("t2b_in5", iv, 16'h1234);
      check("t2b_dac5", dv, 16'h1234);
      check("t2b_count", frame_count, 3);

      // broadcast write-and-update, then clear
      send_frame(32'h003F_8000, 24, 1'b0, lat, nv, ne);
      check("t3_count", frame_count, 4);
      read_ch(0, iv, dv);
      check("t3_in0", iv, 16'h8000);
      check("t3_dac0", dv, 16'h8000);
      read_ch(7, iv, dv);
      check("t3_in7", iv, 16'h8000);
      check("t3_dac7", dv, 16'h8000);
      @(negedge clk);
      clrb = 1'b0;
      wait_clks(10);
      clrb = 1'b1;
      wait_clks(6);
      read_ch(2, iv, dv);
      check("t3_clr_dac2", dv, 0);
      read_ch(7, iv, dv);
      check("t3_clr_in7", iv, 0);
      check("t3_clr_dac7", dv, 0);
      check("t3_clr_count", frame_count, 4);

      // write input 1, then write input 3 and update all DACs
      send_frame(32'h0001_1111, 24, 1'b0, lat, nv, ne);
      send_frame(32'h0023_2222, 24, 1'b0, lat, nv, ne);
      check("t3c_nvalid", nv, 1);
      check("t3c_count", frame_count, 6);
      read_ch(1, iv, dv);
      check("t3c_dac1", dv, 16'h1111);
      read_ch(3, iv, dv);
      check("t3c_in3", iv, 16'h2222);
      check("t3c_dac3", dv, 16'h2222);
      read_ch(0, iv, dv);
      check("t3c_dac0", dv, 0);

      // bad bit counts
      send_frame(32'h0000_5555, 23, 1'b0, lat, nv, ne);
      check("t4a_latency", lat, LAT);
      check("t4a_nerror", ne, 1);
      check("t4a_nvalid", nv, 0);
      check("t4a_count", frame_count, 6);
      check("t4a_data", frame_data, 16'h2222);
      send_frame(32'h0100_5555, 25, 1'b0, lat, nv, ne);
      check("t4b_nerror", ne, 1);
      check("t4b_nvalid", nv, 0);
      check("t4b_count", frame_count, 6);
      check("t4b_cmd", frame_cmd, 2);
      read_ch(0, iv, dv);
      check("t4b_in0", iv, 0);

      // reset in the middle of a frame with csb held low
      start_frame();
      for (int i = 0; i < 11; i++) sck_bit(1'b1);
      sdi = 1'b1;
      wait_clks(3);
      sck = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(2);
      sck = 1'b0;
      check("t5_rst_count", frame_count, 0);
      for (int i = 23; i >= 0; i--) sck_bit(((32'h0037_0FFF >> i) & 32'h1) != 0);
      end_frame(1'b0, lat, nv, ne);
      check("t5_nvalid", nv, 0);
      check("t5_nerror", ne, 0);
      check("t5_count", frame_count, 0);
      read_ch(7, iv, dv);
      check("t5_dac7", dv, 0);
      send_frame(32'h0036_0F0F, 24, 1'b0, lat, nv, ne);
      check("t5b_latency", lat, LAT);
      check("t5b_nvalid", nv, 1);
      check("t5b_count", frame_count, 1);
      read_ch(6, iv, dv);
      check("t5b_dac6", dv, 16'h0F0F);

      // counter wrap; final sck rise lands with the csb rise
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.frame_count_q;
      wait_clks(2);
      check("t6_preset", frame_count, 16'hFFFF);
      send_frame(32'h0000_4321, 24, 1'b1, lat, nv, ne);
      check("t6_nvalid", nv, 1);
      check("t6_nerror", ne, 0);
      check("t6_count_wrap", frame_count, 0);
      check("t6_data", frame_data, 16'h4321);
      read_ch(0, iv, dv);
      check("t6_in0", iv, 16'h4321);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
